// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a write to 16'h4014 halts the CPU and copies one
// 256-byte page to 16'h2004 using alternating read/write bus cycles.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        ready,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       odd_q, odd_d;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= odd_d;
    end
  end

  // Next-state logic and bus ownership mux
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    odd_d     = ~odd_q;
    ready     = 1'b0;
    busy      = 1'b1;
    bus_addr  = cpu_addr;
    bus_write = cpu_write;
    bus_d_out = cpu_d_out;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        // The triggering write itself still reaches the bus this cycle
        if (cpu_write && (cpu_addr == 16'h4014)) begin
          page_d  = cpu_d_out;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        // The CPU may finish a pending write before the DMA takes the bus
        if (cpu_write) begin
          state_d = S_HALT;
        end else if (odd_q) begin
          state_d = S_ALIGN;
        end else begin
          state_d = S_READ;
        end
      end
      S_ALIGN: begin
        bus_write = 1'b0;
        state_d   = S_READ;
      end
      S_READ: begin
        bus_addr  = {page_q, idx_q};
        bus_write = 1'b0;
        bus_d_out = data_q;
        data_d    = bus_d_in;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        bus_addr  = 16'h2004;
        bus_write = 1'b1;
        bus_d_out = data_q;
        idx_d     = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table, directed transfer sequences
// and random CPU traffic against a cycle-counting transfer model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic [7:0]  bus_d_in;
  logic        ready;
  logic        busy;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;

  int total = 0;
  int bad   = 0;

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_write (cpu_write),
    .cpu_d_out (cpu_d_out),
    .bus_d_in  (bus_d_in),
    .ready     (ready),
    .busy      (busy),
    .bus_addr  (bus_addr),
    .bus_write (bus_write),
    .bus_d_out (bus_d_out)
  );

  always #5 clk = ~clk;

  // Memory model: every location returns its low address byte xor 8'h5A
  assign bus_d_in = bus_addr[7:0] ^ 8'h5A;

  // Reference model: 0 idle, 1 halted, 2 align, 3 transferring (k = bus cycle 0..511)
  int         m_phase = 0;
  int         m_k     = 0;
  bit         m_odd   = 1'b0;
  logic [7:0] m_page  = 8'h00;

  int         n2004;
  int         low_cnt;
  logic [7:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic [15:0] e_addr;
    logic        e_wr;
    logic [7:0]  e_dout;
    bit          chk_dout;
    e_addr   = cpu_addr;
    e_wr     = cpu_write;
    e_dout   = cpu_d_out;
    chk_dout = 1'b1;
    if (m_phase == 2) begin
      e_wr = 1'b0;
    end else if (m_phase == 3) begin
      if ((m_k % 2) == 0) begin
        e_addr   = {m_page, 8'(m_k / 2)};
        e_wr     = 1'b0;
        chk_dout = 1'b0;
      end else begin
        e_addr = 16'h2004;
        e_wr   = 1'b1;
        e_dout = 8'(m_k / 2) ^ 8'h5A;
      end
    end
    check("cycle_ctl", {12'h000, ready, busy, bus_write, 1'b0, bus_addr},
          {12'h000, (m_phase == 0), (m_phase != 0), e_wr, 1'b0, e_addr});
    if (chk_dout) check("cycle_dout", {24'h0, bus_d_out}, {24'h0, e_dout});
  endtask

  task automatic model_update(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    if (!r) begin
      m_phase = 0; m_k = 0; m_page = 8'h00; m_odd = 1'b0;
    end else begin
      case (m_phase)
        0: if (w && a == 16'h4014) begin m_page = d; m_phase = 1; end
        1: if (!w) begin m_phase = m_odd ? 2 : 3; m_k = 0; end
        2: begin m_phase = 3; m_k = 0; end
        default: if (m_k == 511) m_phase = 0; else m_k++;
      endcase
      m_odd = ~m_odd;
    end
  endtask

  task automatic drive_sample(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    reset = r; cpu_write = w; cpu_addr = a; cpu_d_out = d;
    #3;
    model_compare();
    if (bus_write && bus_addr == 16'h2004) begin n2004++; wq.push_back(bus_d_out); end
    if (!ready) low_cnt++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(reset, cpu_write, cpu_addr, cpu_d_out);
    #1;
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    drive_sample(r, w, a, d);
    advance();
  endtask

  task automatic clear_stats();
    n2004 = 0; low_cnt = 0; wq.delete();
  endtask

  task automatic run_dma(input int budget, input int poke_at);
    int i = 0;
    while (m_phase != 0 && i < budget) begin
      if (i == poke_at) step(1'b1, 1'b1, 16'h4014, 8'h77);
      else              step(1'b1, 1'b0, 16'h0000, 8'h00);
      i++;
    end
    if (m_phase != 0) check("dma_timeout", 32'(i), 32'(budget + 1));
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  d;
    logic        e_ready;
    logic        e_busy;
    logic        e_wr;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 16'h4015, 8'h11, 1'b1, 1'b0, 1'b1};
    tv[2] = '{1'b1, 1'b1, 16'h2014, 8'h22, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b0, 16'h4014, 8'h23, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b1, 16'h4014, 8'h33, 1'b1, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b1, 1'b1, 16'h4014, 8'h44, 1'b1, 1'b0, 1'b1};
    tv[7] = '{1'b1, 1'b1, 16'h1234, 8'h55, 1'b0, 1'b1, 1'b1};
    tv[8] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
    tv[9] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 8'h00);

    // Vector table: pass-through, non-trigger writes, reset priority, halt entry
    for (int i = 0; i < 10; i++) begin
      drive_sample(tv[i].rst, tv[i].we, tv[i].addr, tv[i].d);
      check($sformatf("tv%0d_ready", i), {31'h0, ready}, {31'h0, tv[i].e_ready});
      check($sformatf("tv%0d_busy", i), {31'h0, busy}, {31'h0, tv[i].e_busy});
      check($sformatf("tv%0d_bus", i), {15'h0, bus_write, bus_addr}, {15'h0, tv[i].e_wr, tv[i].addr});
      advance();
    end

    // Even-cycle trigger: odd=0 during HALT
    if (!m_odd) step(1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 16'h4014, 8'h02);
    clear_stats();
    run_dma(600, -1);
    check("even_low", 32'(low_cnt), 32'd513);
    check("even_writes", 32'(n2004), 32'd256);
    for (int i = 0; i < wq.size() && i < 256; i++)
      check("even_data", {24'h0, wq[i]}, {24'h0, 8'(i) ^ 8'h5A});

    // Odd-cycle trigger: one ALIGN cycle
    if (m_odd) step(1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 16'h4014, 8'h02);
    clear_stats();
    run_dma(600, -1);
    check("odd_low", 32'(low_cnt), 32'd514);
    check("odd_writes", 32'(n2004), 32'd256);

    // Held CPU write for 3 cycles, then a 4014 write mid-transfer
    if (!m_odd) step(1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 16'h4014, 8'h02);
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0300, 8'h99);
    run_dma(600, 50);
    check("held_low", 32'(low_cnt), 32'd517);
    check("held_writes", 32'(n2004), 32'd256);

    // Reset abort during the WRITE of idx 100
    step(1'b1, 1'b1, 16'h4014, 8'h05);
    for (int i = 0; i < 300 && !(m_phase == 3 && m_k == 201); i++)
      step(1'b1, 1'b0, 16'h0000, 8'h00);
    check("abort_reached", {31'h0, (m_phase == 3 && m_k == 201)}, 32'd1);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    clear_stats();
    drive_sample(1'b1, 1'b0, 16'h0000, 8'h00);
    check("abort_ready_busy", {30'h0, ready, busy}, 32'd2);
    advance();
    for (int i = 0; i < 600; i++)
      step(1'b1, 1'($urandom), 16'($urandom) & 16'h0FFF, 8'($urandom));
    check("abort_no_2004", 32'(n2004), 32'd0);
    step(1'b1, 1'b1, 16'h4014, 8'h07);
    clear_stats();
    run_dma(600, -1);
    check("after_abort_writes", 32'(n2004), 32'd256);

    // Random CPU traffic with occasional triggers and resets
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = 16'h4014;
        2:       a = 16'h2004;
        3:       a = 16'h4015;
        default: a = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 799) != 0), 1'($urandom), a, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
